regfile_mp: RTL and testbench

- Parametrised multi-read-port register file for the single-cycle/pipelined CPU datapath.
- Next generation of the existing 32x32, 2-read/1-write register file, with these additions:
  - configurable width, depth and read-port count;
  - synchronous reset clear;
  - write-to-read bypass;
  - per-register busy scoreboard used by the decode stage to detect pending writes.
- Sits between decode (read/reserve) and writeback (write).

---
 rtl/regfile_mp.sv | 102 ++++++++++
 tb/tb_regfile_mp.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with synchronous clear, write-to-read bypass
// and a per-register busy scoreboard for pending-write detection.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_RD-1:0]        rd_busy
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        regs_q [DEPTH];
    logic [DATA_W-1:0]        regs_d [DEPTH];
    logic [DEPTH-1:0]         busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0] rd_q, rd_d;
    logic [NUM_RD-1:0]        rd_valid_q, rd_valid_d;
    logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;
    logic [ADDR_W-1:0]        rd_addr [NUM_RD];
    logic                     wr_ok;
    logic                     rsv_ok;

    // Register 0 swallows writes and reserves when it is hardwired to zero.
    always_comb begin
        wr_ok  = we && !((ZERO_REG != 0) && (wa == '0));
        rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr[i] = ra[i*ADDR_W +: ADDR_W];
        end
    end

    // Reserve is applied after the write so a same-cycle reserve leaves busy set.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[wa] = wd;
            busy_d[wa] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // rd_valid is a one-cycle strobe with no back-pressure: the consumer must
    // take rd in the cycle rd_valid is high; rd itself holds until the next read.
    always_comb begin
        rd_d       = rd_q;
        rd_valid_d = '0;
        rd_busy_d  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (re[i]) begin
                rd_valid_d[i] = 1'b1;
                if ((ZERO_REG != 0) && (rd_addr[i] == '0)) begin
                    rd_d[i*DATA_W +: DATA_W] = '0;
                    rd_busy_d[i]             = 1'b0;
                end else if ((BYPASS != 0) && wr_ok && (rd_addr[i] == wa)) begin
                    rd_d[i*DATA_W +: DATA_W] = wd;
                    rd_busy_d[i]             = 1'b0;
                end else begin
                    rd_d[i*DATA_W +: DATA_W] = regs_q[rd_addr[i]];
                    rd_busy_d[i]             = busy_q[rd_addr[i]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= '0;
            end
            busy_q     <= '0;
            rd_q       <= '0;
            rd_valid_q <= '0;
            rd_busy_q  <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            rd_busy_q  <= rd_busy_d;
        end
    end

    assign rd       = rd_q;
    assign rd_valid = rd_valid_q;
    assign rd_busy  = rd_busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default, read-first (BYPASS=0) and a narrow 4-port
// instance, all checked against an array-based behavioural model.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the two 32x32 instances (write-first / read-first)
    logic        we = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    logic        rsv_en = 1'b0;
    logic [4:0]  rsv_addr = '0;
    logic [1:0]  re = '0;
    logic [9:0]  ra = '0;
    logic [63:0] rd_a, rd_b;
    logic [1:0]  val_a, val_b, busy_a, busy_b;

    // Narrow instance: 16-bit, 8 entries, 4 read ports, ordinary register 0
    logic        c_we = 1'b0;
    logic [2:0]  c_wa = '0;
    logic [15:0] c_wd = '0;
    logic        c_rsv_en = 1'b0;
    logic [2:0]  c_rsv_addr = '0;
    logic [3:0]  c_re = '0;
    logic [11:0] c_ra = '0;
    logic [63:0] c_rd;
    logic [3:0]  c_val, c_busy;

    regfile_mp u_a (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .re(re), .ra(ra),
        .rd(rd_a), .rd_valid(val_a), .rd_busy(busy_a)
    );

    regfile_mp #(.BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .re(re), .ra(ra),
        .rd(rd_b), .rd_valid(val_b), .rd_busy(busy_b)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0), .BYPASS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .we(c_we), .wa(c_wa), .wd(c_wd),
        .rsv_en(c_rsv_en), .rsv_addr(c_rsv_addr), .re(c_re), .ra(c_ra),
        .rd(c_rd), .rd_valid(c_val), .rd_busy(c_busy)
    );

    // Reference model state
    logic [31:0] m_reg [32];
    bit          m_busy [32];
    logic [63:0] ea_rd, eb_rd;
    logic [1:0]  ea_val, eb_val, ea_busy, eb_busy;
    logic [15:0] c_mem [8];
    logic [63:0] ec_rd;
    logic [3:0]  ec_val;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Applies the rules for one rising edge using the inputs currently driven.
    task automatic model_step();
        logic [4:0]  a;
        logic [2:0]  ca;
        logic [31:0] old;
        bit          ob;
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) begin
                m_reg[k]  = '0;
                m_busy[k] = 1'b0;
            end
            for (int k = 0; k < 8; k++) c_mem[k] = '0;
            ea_rd = '0; eb_rd = '0; ea_val = '0; eb_val = '0;
            ea_busy = '0; eb_busy = '0;
            ec_rd = '0; ec_val = '0;
            return;
        end
        for (int i = 0; i < 2; i++) begin
            a          = ra[i*5 +: 5];
            ea_val[i]  = re[i];
            eb_val[i]  = re[i];
            ea_busy[i] = 1'b0;
            eb_busy[i] = 1'b0;
            if (re[i]) begin
                old = (a == 0) ? 32'h0 : m_reg[a];
                ob  = (a == 0) ? 1'b0 : m_busy[a];
                eb_rd[i*32 +: 32] = old;
                eb_busy[i]        = ob;
                if (we && wa == a && a != 0) begin
                    ea_rd[i*32 +: 32] = wd;
                    ea_busy[i]        = 1'b0;
                end else begin
                    ea_rd[i*32 +: 32] = old;
                    ea_busy[i]        = ob;
                end
            end
        end
        if (we && wa != 0) begin
            m_reg[wa]  = wd;
            m_busy[wa] = 1'b0;
        end
        if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ca        = c_ra[i*3 +: 3];
            ec_val[i] = c_re[i];
            if (c_re[i]) ec_rd[i*16 +: 16] = (c_we && c_wa == ca) ? c_wd : c_mem[ca];
        end
        if (c_we) c_mem[c_wa] = c_wd;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("a_rd", rd_a, ea_rd);
        chk("a_valid", val_a, ea_val);
        chk("a_busy", busy_a, ea_busy);
        chk("b_rd", rd_b, eb_rd);
        chk("b_valid", val_b, eb_val);
        chk("b_busy", busy_b, eb_busy);
        chk("c_rd", c_rd, ec_rd);
        chk("c_valid", c_val, ec_val);
        chk("c_busy", c_busy, 4'h0);
    endtask

    task automatic idle();
        we = 1'b0; rsv_en = 1'b0; re = '0;
        c_we = 1'b0; c_re = '0;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        idle();
        we = 1'b1; wa = addr; wd = data;
        tick();
    endtask

    task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
        idle();
        re = 2'b11; ra = {a1, a0};
        tick();
    endtask

    initial begin
        // Reset state
        idle();
        tick();
        tick();
        rst_n = 1'b1;

        // Reset clears a previously written register; outputs zero during reset
        wr(5'd5, 32'hDEADBEEF);
        idle();
        rst_n = 1'b0;
        re = 2'b11; ra = {5'd5, 5'd5};
        tick();
        chk("rst_valid_zero", val_a, 2'b00);
        rst_n = 1'b1;
        rd2(5'd5, 5'd5);
        chk("rst_r5_cleared", rd_a[31:0], 32'h0);
        chk("rst_r5_notbusy", busy_a, 2'b00);

        // Write then read latency, then hold
        wr(5'd3, 32'h12345678);
        idle();
        re = 2'b01; ra = {5'd0, 5'd3};
        tick();
        chk("lat_rd0", rd_a[31:0], 32'h12345678);
        chk("lat_valid0", val_a[0], 1'b1);
        idle();
        tick();
        chk("hold_rd0", rd_a[31:0], 32'h12345678);
        chk("hold_valid0", val_a[0], 1'b0);

        // Bypass versus read-first on both ports
        wr(5'd7, 32'h1);
        idle();
        we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5;
        re = 2'b11; ra = {5'd7, 5'd7};
        tick();
        chk("bypass_wf", rd_a, {2{32'hA5A5A5A5}});
        chk("bypass_rf", rd_b, {2{32'h00000001}});

        // Zero register ignores write and reserve
        idle();
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        tick();
        rd2(5'd0, 5'd0);
        chk("zero_rd", rd_a, 64'h0);
        chk("zero_busy", busy_a, 2'b00);

        // Busy scoreboard sequence
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        rd2(5'd9, 5'd9);
        chk("sb_rsv_busy", busy_a, 2'b11);
        idle();
        we = 1'b1; wa = 5'd9; wd = 32'h55;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        rd2(5'd9, 5'd9);
        chk("sb_wr_rsv_data", rd_a[31:0], 32'h55);
        chk("sb_wr_rsv_busy", busy_a, 2'b11);
        wr(5'd9, 32'h66);
        rd2(5'd9, 5'd9);
        chk("sb_wr_data", rd_a[31:0], 32'h66);
        chk("sb_wr_busy", busy_a, 2'b00);

        // Narrow instance: fill all 8 entries, read through 4 ports
        for (int k = 0; k < 8; k++) begin
            idle();
            c_we = 1'b1; c_wa = 3'(k); c_wd = 16'(k * 16'h1111);
            tick();
        end
        idle();
        c_re = 4'hF; c_ra = {3'd3, 3'd2, 3'd1, 3'd0};
        tick();
        chk("sweep_lo", c_rd, 64'h3333_2222_1111_0000);
        idle();
        c_re = 4'hF; c_ra = {3'd7, 3'd6, 3'd5, 3'd4};
        tick();
        chk("sweep_hi", c_rd, 64'h7777_6666_5555_4444);
        chk("sweep_r7", c_rd[63:48], 16'h7777);
        idle();
        c_we = 1'b1; c_wa = 3'd0; c_wd = 16'hBEEF;
        tick();
        idle();
        c_re = 4'h1; c_ra = 12'h0;
        tick();
        chk("c_r0_ordinary", c_rd[15:0], 16'hBEEF);

        // Randomized traffic, addresses biased toward a small set for collisions
        for (int n = 0; n < 400; n++) begin
            idle();
            rst_n    = ($urandom_range(0, 79) != 0);
            we       = 1'($urandom_range(0, 1));
            wa       = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 5));
            wd       = $urandom;
            rsv_en   = 1'($urandom_range(0, 2) == 0);
            rsv_addr = 5'($urandom_range(0, 5));
            re       = 2'($urandom_range(0, 3));
            ra       = {5'($urandom_range(0, 5)), 5'($urandom_range(0, 5))};
            c_we     = 1'($urandom_range(0, 1));
            c_wa     = 3'($urandom_range(0, 7));
            c_wd     = 16'($urandom);
            c_re     = 4'($urandom_range(0, 15));
            c_ra     = 12'($urandom);
            tick();
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
